// File: rtl/strided_tile_streamer.sv
// Command-driven strided row loader: issues credit-limited memory reads at base + k*stride,
// buffers responses in a row FIFO and streams them out over ready/valid with last.
module strided_tile_streamer #(
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned N                   = 4,
    parameter int unsigned MEMORY_ADDRESS_BITS = 64,
    parameter int unsigned MAX_MATRIX_LENGTH   = 4096,
    parameter int unsigned COUNTER_BITS        = $clog2(MAX_MATRIX_LENGTH + 1),
    parameter int unsigned FIFO_DEPTH          = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [MEMORY_ADDRESS_BITS-1:0] cmd_addr_i,
    input  logic [MEMORY_ADDRESS_BITS-1:0] cmd_stride_i,
    input  logic [COUNTER_BITS-1:0]        cmd_len_i,
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [MEMORY_ADDRESS_BITS-1:0] mem_req_addr_o,
    input  logic                           mem_rsp_valid_i,
    input  logic [N*DATA_WIDTH-1:0]        mem_rsp_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [N*DATA_WIDTH-1:0]        out_data_o,
    output logic                           out_last_o,
    output logic                           busy_o,
    output logic                           err_unexpected_rsp_o
);

    localparam int unsigned RowWidth = N * DATA_WIDTH;
    localparam int unsigned PtrBits  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntBits  = $clog2(FIFO_DEPTH + 1);
    localparam logic [COUNTER_BITS-1:0] MaxLen = COUNTER_BITS'(MAX_MATRIX_LENGTH);
    localparam logic [CntBits:0] DepthLimit = (CntBits + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                         state_q, state_d;
    logic [MEMORY_ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [MEMORY_ADDRESS_BITS-1:0] stride_q, stride_d;
    logic [COUNTER_BITS-1:0]        len_q, len_d;
    logic [COUNTER_BITS-1:0]        issued_q, issued_d;
    logic [COUNTER_BITS-1:0]        delivered_q, delivered_d;
    logic [CntBits-1:0]             outstanding_q, outstanding_d;
    logic [CntBits-1:0]             count_q, count_d;
    logic [PtrBits-1:0]             wr_ptr_q, rd_ptr_q;
    logic [RowWidth-1:0]            fifo_q [FIFO_DEPTH];
    logic                           err_q;

    logic [COUNTER_BITS-1:0] len_clamped;
    logic [CntBits:0]        inflight;
    logic                    credit_ok;
    logic                    req_fire;
    logic                    rsp_accept;
    logic                    pop;

    assign len_clamped = (cmd_len_i > MaxLen) ? MaxLen : cmd_len_i;

    // Every outstanding read owns a FIFO slot, so responses can never overflow it.
    assign inflight  = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit_ok = inflight < DepthLimit;

    assign cmd_ready_o     = (state_q == StIdle);
    assign busy_o          = (state_q != StIdle);
    assign mem_req_valid_o = (state_q == StIssue) && credit_ok;
    assign mem_req_addr_o  = addr_q;
    assign req_fire        = mem_req_valid_o && mem_req_ready_i;
    assign rsp_accept      = mem_rsp_valid_i && (outstanding_q != '0);

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? fifo_q[rd_ptr_q] : '0;
    assign out_last_o  = out_valid_o && (delivered_q == len_q - 1'b1);
    assign pop         = out_valid_o && out_ready_i;

    assign err_unexpected_rsp_o = err_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d      = cmd_addr_i;
                    stride_d    = cmd_stride_i;
                    len_d       = len_clamped;
                    issued_d    = '0;
                    delivered_d = '0;
                    if (len_clamped != '0) begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (req_fire) begin
                    addr_d   = addr_q + stride_q;
                    issued_d = issued_q + 1'b1;
                    if (issued_q == len_q - 1'b1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && out_last_o) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            delivered_d = delivered_q + 1'b1;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({req_fire, rsp_accept})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({rsp_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            stride_q      <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            delivered_q   <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            stride_q      <= stride_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            delivered_q   <= delivered_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            if (rsp_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (mem_rsp_valid_i && (outstanding_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Row storage needs no reset: the read side is gated by the cleared count.
    always_ff @(posedge clk) begin
        if (rsp_accept) begin
            fifo_q[wr_ptr_q] <= mem_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_strided_tile_streamer.sv
// Self-checking bench: latency/backpressure memory model, directed scenarios and a
// randomized run scored against rows computed from base + k*stride.
module tb_strided_tile_streamer;

    localparam int unsigned DW   = 8;
    localparam int unsigned NE   = 4;
    localparam int unsigned AW   = 64;
    localparam int unsigned MAXL = 4096;
    localparam int unsigned CB   = $clog2(MAXL + 1);
    localparam int unsigned FD   = 8;
    localparam int unsigned RW   = DW * NE;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i;
    logic [AW-1:0] cmd_stride_i;
    logic [CB-1:0] cmd_len_i;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i;
    logic [AW-1:0] mem_req_addr_o;
    logic          mem_rsp_valid_i;
    logic [RW-1:0] mem_rsp_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [RW-1:0] out_data_o;
    logic          out_last_o;
    logic          busy_o;
    logic          err_unexpected_rsp_o;

    strided_tile_streamer #(
        .DATA_WIDTH         (DW),
        .N                  (NE),
        .MEMORY_ADDRESS_BITS(AW),
        .MAX_MATRIX_LENGTH  (MAXL),
        .COUNTER_BITS       (CB),
        .FIFO_DEPTH         (FD)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid_i         (cmd_valid_i),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_addr_i          (cmd_addr_i),
        .cmd_stride_i        (cmd_stride_i),
        .cmd_len_i           (cmd_len_i),
        .mem_req_valid_o     (mem_req_valid_o),
        .mem_req_ready_i     (mem_req_ready_i),
        .mem_req_addr_o      (mem_req_addr_o),
        .mem_rsp_valid_i     (mem_rsp_valid_i),
        .mem_rsp_data_i      (mem_rsp_data_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .out_data_o          (out_data_o),
        .out_last_o          (out_last_o),
        .busy_o              (busy_o),
        .err_unexpected_rsp_o(err_unexpected_rsp_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int req_pct = 100;
    int out_pct = 100;
    int lat_min = 2;
    int lat_max = 2;
    int last_due = 0;

    logic [AW-1:0] req_log[$];
    logic [RW-1:0] out_data_log[$];
    logic          out_last_log[$];
    logic [RW-1:0] rsp_data_q[$];
    int            rsp_due_q[$];
    logic [RW-1:0] exp_data[$];
    logic          exp_last[$];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [RW-1:0] word_of(input logic [AW-1:0] a);
        logic [31:0] w;
        w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
        return RW'(w);
    endfunction

    task automatic clear_logs();
        req_log.delete();
        out_data_log.delete();
        out_last_log.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic clear_mem();
        rsp_data_q.delete();
        rsp_due_q.delete();
        last_due = 0;
    endtask

    // One cycle: drive inputs at the falling edge and log the handshakes the next rising
    // edge will perform (all DUT outputs are register-driven).
    task automatic step();
        int lat;
        @(negedge clk);
        cyc++;
        mem_req_ready_i = ($urandom_range(99) < req_pct);
        out_ready_i     = ($urandom_range(99) < out_pct);
        if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = rsp_data_q.pop_front();
            void'(rsp_due_q.pop_front());
        end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = RW'($urandom);
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
            lat = $urandom_range(lat_max, lat_min);
            req_log.push_back(mem_req_addr_o);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            rsp_due_q.push_back(last_due);
            rsp_data_q.push_back(word_of(mem_req_addr_o));
        end
        if (out_valid_o && out_ready_i) begin
            out_data_log.push_back(out_data_o);
            out_last_log.push_back(out_last_o);
        end
    endtask

    task automatic expect_rows(input logic [AW-1:0] a, input logic [AW-1:0] s, input int len);
        int n;
        n = (len > int'(MAXL)) ? int'(MAXL) : len;
        for (int k = 0; k < n; k++) begin
            exp_data.push_back(word_of(a + AW'(k) * s));
            exp_last.push_back(k == n - 1);
        end
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] s,
                            input logic [CB-1:0] l);
        int guard;
        guard = 0;
        while (!cmd_ready_o && guard < 20000) begin
            step();
            guard++;
        end
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_timeout: got %b required 1", cmd_ready_o);
        end
        cmd_valid_i  = 1'b1;
        cmd_addr_i   = a;
        cmd_stride_i = s;
        cmd_len_i    = l;
        step();
        cmd_valid_i  = 1'b0;
        cmd_addr_i   = $urandom;
        cmd_len_i    = CB'($urandom);
    endtask

    task automatic run_until_rows(input int n, input int budget);
        int c;
        c = 0;
        while (out_data_log.size() < n && c < budget) begin
            step();
            c++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        clear_mem();
        step();
        clear_mem();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cmd_ready_o !== 1'b1) begin errors++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready_o); end
        checks++; if (mem_req_valid_o !== 1'b0 || out_valid_o !== 1'b0 || out_last_o !== 1'b0)
            begin errors++; $display("FAIL reset_valids: got req=%b out=%b last=%b required 0",
                                     mem_req_valid_o, out_valid_o, out_last_o); end
        checks++; if (busy_o !== 1'b0 || err_unexpected_rsp_o !== 1'b0) begin errors++;
            $display("FAIL reset_busy_err: got busy=%b err=%b required 0", busy_o,
                     err_unexpected_rsp_o); end
        checks++; if (out_data_o !== '0 || mem_req_addr_o !== '0) begin errors++;
            $display("FAIL reset_data_addr: got data=%h addr=%h required 0", out_data_o,
                     mem_req_addr_o); end
    endtask

    task automatic test_basic();
        clear_logs();
        req_pct = 100; out_pct = 100; lat_min = 2; lat_max = 2;
        send_cmd(64'h100, 64'h4, CB'(3));
        checks++; if (mem_req_valid_o !== 1'b1 || busy_o !== 1'b1) begin errors++;
            $display("FAIL basic_first_req: got valid=%b busy=%b required 1 1",
                     mem_req_valid_o, busy_o); end
        run_until_rows(3, 100);
        checks++; if (cmd_ready_o !== 1'b0) begin errors++;
            $display("FAIL basic_ready_with_last: got %b required 0", cmd_ready_o); end
        step();
        checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++;
            $display("FAIL basic_ready_after: got ready=%b busy=%b required 1 0",
                     cmd_ready_o, busy_o); end
        checks++; if (req_log.size() != 3 || out_data_log.size() != 3) begin errors++;
            $display("FAIL basic_counts: got req=%0d rows=%0d required 3 3",
                     req_log.size(), out_data_log.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (req_log[k] !== 64'h100 + 64'(4 * k)) begin errors++;
                    $display("FAIL basic_addr%0d: got %h required %h", k, req_log[k],
                             64'h100 + 64'(4 * k)); end
                checks++;
                if (out_data_log[k] !== word_of(64'h100 + 64'(4 * k)) ||
                    out_last_log[k] !== (k == 2)) begin errors++;
                    $display("FAIL basic_row%0d: got %h/%b required %h/%b", k, out_data_log[k],
                             out_last_log[k], word_of(64'h100 + 64'(4 * k)), k == 2); end
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        clear_logs();
        req_pct = 100; out_pct = 0; lat_min = 2; lat_max = 2;
        send_cmd(64'h2000, 64'h40, CB'(20));
        expect_rows(64'h2000, 64'h40, 20);
        for (int i = 0; i < 40; i++) step();
        checks++; if (req_log.size() != FD || mem_req_valid_o !== 1'b0) begin errors++;
            $display("FAIL bp_credit: got reqs=%0d valid=%b required %0d 0", req_log.size(),
                     mem_req_valid_o, FD); end
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== exp_data[0] || out_last_o !== 1'b0)
            begin errors++; $display("FAIL bp_hold: got %b %h %b required 1 %h 0", out_valid_o,
                                     out_data_o, out_last_o, exp_data[0]); end
        out_pct = 100;
        run_until_rows(20, 300);
        for (int i = 0; i < 5; i++) step();
        checks++; if (req_log.size() != 20 || out_data_log.size() != 20) begin errors++;
            $display("FAIL bp_counts: got req=%0d rows=%0d required 20 20", req_log.size(),
                     out_data_log.size()); end
        else begin
            bad = 0;
            for (int k = 0; k < 20; k++)
                if (out_data_log[k] !== exp_data[k] || out_last_log[k] !== exp_last[k]) bad++;
            checks++; if (bad != 0) begin errors++;
                $display("FAIL bp_rows: got %0d bad rows required 0", bad); end
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        send_cmd(64'h300, 64'h4, CB'(0));
        checks++; if (mem_req_valid_o !== 1'b0 || out_valid_o !== 1'b0 || busy_o !== 1'b0 ||
                      cmd_ready_o !== 1'b1) begin errors++;
            $display("FAIL zero_len: got req=%b out=%b busy=%b ready=%b required 0 0 0 1",
                     mem_req_valid_o, out_valid_o, busy_o, cmd_ready_o); end
        for (int i = 0; i < 5; i++) step();
        checks++; if (req_log.size() != 0 || out_data_log.size() != 0) begin errors++;
            $display("FAIL zero_len_quiet: got req=%0d rows=%0d required 0 0", req_log.size(),
                     out_data_log.size()); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a;
        clear_logs();
        a = 64'hFFFF_FFFF_FFFF_FFFC;
        send_cmd(a, 64'h4, CB'(3));
        run_until_rows(3, 100);
        checks++; if (req_log.size() != 3) begin errors++;
            $display("FAIL wrap_count: got %0d required 3", req_log.size()); end
        else begin
            checks++; if (req_log[0] !== a || req_log[1] !== 64'h0 || req_log[2] !== 64'h4)
                begin errors++; $display("FAIL wrap_addr: got %h %h %h required %h 0 4",
                                         req_log[0], req_log[1], req_log[2], a); end
        end
        checks++; if (out_data_log.size() != 3) begin errors++;
            $display("FAIL wrap_rows: got %0d required 3", out_data_log.size()); end
        else begin
            checks++; if (out_data_log[1] !== word_of(64'h0) || out_last_log[2] !== 1'b1) begin
                errors++; $display("FAIL wrap_data: got %h/%b required %h/1", out_data_log[1],
                                   out_last_log[2], word_of(64'h0)); end
        end
        step();
    endtask

    task automatic test_unexpected_rsp();
        step();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hDEAD_BEEF;
        step();
        checks++; if (err_unexpected_rsp_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++;
            $display("FAIL unexp_rsp: got err=%b out_valid=%b required 1 0",
                     err_unexpected_rsp_o, out_valid_o); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (err_unexpected_rsp_o !== 1'b1) begin errors++;
            $display("FAIL unexp_sticky: got %b required 1", err_unexpected_rsp_o); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        req_pct = 100; out_pct = 100; lat_min = 2; lat_max = 2;
        send_cmd(64'h4000, 64'h10, CB'(10));
        run_until_rows(5, 100);
        reset = 1'b1;
        clear_mem();
        step();
        clear_mem();
        reset = 1'b0;
        checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || mem_req_valid_o !== 1'b0 ||
                      out_valid_o !== 1'b0 || out_last_o !== 1'b0) begin errors++;
            $display("FAIL midreset_ctrl: got rdy=%b busy=%b req=%b out=%b last=%b required 1 0 0 0 0",
                     cmd_ready_o, busy_o, mem_req_valid_o, out_valid_o, out_last_o); end
        checks++; if (out_data_o !== '0 || mem_req_addr_o !== '0 || err_unexpected_rsp_o !== 1'b0)
            begin errors++; $display("FAIL midreset_data: got data=%h addr=%h err=%b required 0",
                                     out_data_o, mem_req_addr_o, err_unexpected_rsp_o); end
        clear_logs();
        send_cmd(64'h5000, 64'h8, CB'(1));
        run_until_rows(1, 100);
        for (int i = 0; i < 10; i++) step();
        checks++; if (req_log.size() != 1 || out_data_log.size() != 1) begin errors++;
            $display("FAIL midreset_new: got req=%0d rows=%0d required 1 1", req_log.size(),
                     out_data_log.size()); end
        else begin
            checks++; if (out_data_log[0] !== word_of(64'h5000) || out_last_log[0] !== 1'b1) begin
                errors++; $display("FAIL midreset_row: got %h/%b required %h/1", out_data_log[0],
                                   out_last_log[0], word_of(64'h5000)); end
        end
    endtask

    task automatic test_clamp();
        int bad;
        int lasts;
        clear_logs();
        req_pct = 100; out_pct = 100; lat_min = 2; lat_max = 2;
        send_cmd(64'h10000, 64'h20, CB'(5000));
        expect_rows(64'h10000, 64'h20, 5000);
        run_until_rows(MAXL + 10, 6000);
        for (int i = 0; i < 20; i++) step();
        checks++; if (req_log.size() != MAXL || out_data_log.size() != MAXL) begin errors++;
            $display("FAIL clamp_counts: got req=%0d rows=%0d required %0d", req_log.size(),
                     out_data_log.size(), MAXL); end
        else begin
            bad = 0; lasts = 0;
            for (int k = 0; k < int'(MAXL); k++) begin
                if (out_data_log[k] !== exp_data[k] || out_last_log[k] !== exp_last[k]) bad++;
                if (out_last_log[k]) lasts++;
            end
            checks++; if (bad != 0 || lasts != 1) begin errors++;
                $display("FAIL clamp_rows: got bad=%0d lasts=%0d required 0 1", bad, lasts); end
        end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++;
            $display("FAIL clamp_idle: got %b required 1", cmd_ready_o); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [AW-1:0] s;
        int len;
        int bad;
        int lasts;
        int cmds_nonzero;
        clear_logs();
        req_pct = 70; out_pct = 60; lat_min = 1; lat_max = 6;
        cmds_nonzero = 0;
        for (int c = 0; c < 200; c++) begin
            a   = {$urandom, $urandom};
            s   = ($urandom_range(3) == 0) ? {$urandom, $urandom} : AW'($urandom_range(256));
            len = $urandom_range(12);
            if (len > 0) cmds_nonzero++;
            send_cmd(a, s, CB'(len));
            expect_rows(a, s, len);
            for (int g = $urandom_range(3); g > 0; g--) step();
        end
        run_until_rows(exp_data.size(), 5000);
        for (int i = 0; i < 20; i++) step();
        checks++; if (out_data_log.size() != exp_data.size() || req_log.size() != exp_data.size())
            begin errors++; $display("FAIL rand_counts: got rows=%0d req=%0d required %0d",
                                     out_data_log.size(), req_log.size(), exp_data.size()); end
        else begin
            bad = 0; lasts = 0;
            for (int k = 0; k < exp_data.size(); k++) begin
                checks++;
                if (out_data_log[k] !== exp_data[k] || out_last_log[k] !== exp_last[k]) begin
                    errors++; bad++;
                    if (bad < 10)
                        $display("FAIL rand_row%0d: got %h/%b required %h/%b", k, out_data_log[k],
                                 out_last_log[k], exp_data[k], exp_last[k]);
                end
                if (out_last_log[k]) lasts++;
            end
            checks++; if (lasts != cmds_nonzero) begin errors++;
                $display("FAIL rand_lasts: got %0d required %0d", lasts, cmds_nonzero); end
        end
        checks++; if (err_unexpected_rsp_o !== 1'b0) begin errors++;
            $display("FAIL rand_err: got %b required 0", err_unexpected_rsp_o); end
    endtask

    initial begin
        reset           = 1'b1;
        cmd_valid_i     = 1'b0;
        cmd_addr_i      = '0;
        cmd_stride_i    = '0;
        cmd_len_i       = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        out_ready_i     = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_unexpected_rsp();
        test_reset_mid();
        test_clamp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
